sort_frame_loader: RTL

- Upstream feeder for the team's sequential insertion sorter.
- Accepts a byte stream on a valid/ready handshake and packs N bytes into one frame.
- Hands each frame to the sorter with a one-cycle `start` pulse, then tracks the sorter's `done` before launching the next frame.
- A fill buffer and a launch register are kept separately, so the next frame fills while the current one sorts.

---
 rtl/sort_pkg.sv | 7 +
 rtl/sort_fill_buf.sv | 61 ++++++
 rtl/sort_frame_loader.sv | 76 +++++++
 3 files changed

// File: rtl/sort_pkg.sv
// sort_pkg: shared element width, launch-state encoding and default pad value
// for the sorter, its frame loader and the downstream collector.
package sort_pkg;
    localparam int SORT_W = 8;
    localparam logic [SORT_W-1:0] PAD_DEFAULT = 8'hFF;
    typedef enum logic [1:0] {IDLE, START, ARM, WAIT} launch_state_t;
endpackage

// File: rtl/sort_fill_buf.sv
// sort_fill_buf: packs accepted bytes into lanes 0..N-1 and raises o_full on the
// N-th byte; an optional flush pads the unfilled lanes with PAD.
module sort_fill_buf
    import sort_pkg::*;
#(
    parameter int N = 4,
    parameter logic [SORT_W-1:0] PAD = PAD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SORT_W-1:0]     i_data,
    input  logic                  i_valid,
    input  logic                  i_flush,
    input  logic                  i_clear,
    output logic                  o_ready,
    output logic                  o_full,
    output logic [N*SORT_W-1:0]   o_data
);
    logic [3:0]          r_cnt;
    logic                r_full;
    logic [N*SORT_W-1:0] r_buf;
    logic [N*SORT_W-1:0] w_buf;
    logic                w_acc;
    logic                w_last;
    logic                w_pad;
    logic [4:0]          w_fill;
    assign w_acc   = i_valid && !r_full;
    assign w_last  = w_acc && (r_cnt == 4'(N - 1));
    assign w_fill  = {1'b0, r_cnt} + 5'(w_acc);
    // the same-cycle byte lands first; a byte that completes the frame suppresses padding
    assign w_pad   = i_flush && !r_full && !w_last && (w_fill != 5'd0);
    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_buf;
    always_comb begin
        w_buf = r_buf;
        if (w_acc)
            w_buf[r_cnt*SORT_W +: SORT_W] = i_data;
        if (w_pad)
            for (int k = 0; k < N; k++)
                if (5'(k) >= w_fill)
                    w_buf[k*SORT_W +: SORT_W] = PAD;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_buf  <= '0;
        end else begin
            r_buf <= w_buf;
            if (i_clear)
                r_full <= 1'b0;
            if (w_last || w_pad) begin
                r_full <= 1'b1;
                r_cnt  <= '0;
            end else if (w_acc) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end
endmodule

// File: rtl/sort_frame_loader.sv
// sort_frame_loader: fills N-byte frames and launches each to the sorter, waiting
// for its done before the next launch. SORT_LOADER_FLUSH_EN adds the flush port.
module sort_frame_loader
    import sort_pkg::*;
#(
    parameter int N = 4,
    parameter logic [SORT_W-1:0] PAD = PAD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SORT_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
`ifdef SORT_LOADER_FLUSH_EN
    input  logic                  flush,
`endif
    output logic                  sort_start,
    output logic [N*SORT_W-1:0]   sort_data,
    input  logic                  sort_done,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);
    launch_state_t       r_state;
    launch_state_t       w_next;
    logic [N*SORT_W-1:0] r_sort_data;
    logic [15:0]         r_frame_cnt;
    logic [N*SORT_W-1:0] w_fill_data;
    logic                w_full;
    logic                w_flush;
    logic                w_load;
`ifdef SORT_LOADER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif
    assign w_load = (r_state == IDLE) && w_full;
    sort_fill_buf #(.N(N), .PAD(PAD)) u_fill (
        .clk     (clk),
        .rst     (rst),
        .i_data  (in_data),
        .i_valid (in_valid),
        .i_flush (w_flush),
        .i_clear (w_load),
        .o_ready (in_ready),
        .o_full  (w_full),
        .o_data  (w_fill_data)
    );
    // ARM skips sort_done because the sorter may still show done from the last frame
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_full ? START : IDLE;
            START:   w_next = ARM;
            ARM:     w_next = WAIT;
            WAIT:    w_next = sort_done ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sort_data <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_sort_data <= w_fill_data;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end
    assign sort_start = (r_state == START);
    assign busy       = (r_state != IDLE);
    assign sort_data  = r_sort_data;
    assign frame_cnt  = r_frame_cnt;
endmodule
